// File: rtl/v74x_pkg.sv
// Shared definitions for the v74x148 sequential priority encoder.
// Holds the FSM state encoding and the default request/code widths.
package v74x_pkg;
  localparam int N_DEF = 8;
  localparam int W_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/v74x148_seq_encoder_prio_enc.sv
// Combinational priority encoder: highest set bit of i_in wins.
// Also produces the one-hot mask of the winning bit for clearing.
module prio_enc_comb
  import v74x_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [N-1:0] i_in,
  output logic [W-1:0] o_idx,
  output logic         o_any,
  output logic [N-1:0] o_onehot
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_in[i]) o_idx = W'(i);
    end
  end

  assign o_any    = |i_in;
  assign o_onehot = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/v74x148_seq_encoder.sv
// Registered priority encoder with falling-edge request capture and
// a VALID/ACK handshake on the presented code.
module v74x148_seq_encoder
  import v74x_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         G_L,
  input  logic [N-1:0] I_L,
  input  logic         ACK,
  output logic [W-1:0] A,
  output logic         VALID,
  output logic         PEND,
  output logic         OVF
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_prev_i_l;
  logic [N-1:0]   r_pending;
  logic [W-1:0]   r_a;
  logic           r_valid;
  logic           r_ovf;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_onehot;
  logic [N-1:0]   w_pending_nxt;
  logic [W-1:0]   w_idx;
  logic           w_any;
  logic           w_load;
  logic [W-1:0]   w_a_nxt;
  logic           w_valid_nxt;

  prio_enc_comb #(.N(N), .W(W)) u_prio (
    .i_in     (r_pending),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_onehot (w_onehot)
  );

  assign w_rise = r_prev_i_l & ~I_L;
  assign w_clr  = w_load ? w_onehot : '0;
  // A fresh rise on the granted bit re-arms it: set beats clear.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!G_L && w_any) begin
          w_load      = 1'b1;
          w_a_nxt     = w_idx;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ACK) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_prev_i_l <= '1;
      r_pending  <= '0;
      r_a        <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_i_l <= I_L;
      r_pending  <= w_pending_nxt;
      r_a        <= w_a_nxt;
      r_valid    <= w_valid_nxt;
      r_ovf      <= r_ovf | (|(w_rise & r_pending & ~w_clr));
    end
  end

  assign A     = r_a;
  assign VALID = r_valid;
  assign PEND  = |r_pending;
  assign OVF   = r_ovf;

endmodule
